// File: rtl/parse_stage_sequencer_pkg.sv
// Shared types for the L2 parse sequencer: stage FSM states and the committed metadata record.
package eth_parser_pkg;

  localparam int PSS_DEFAULT_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HDR,
    WAIT_VLAN,
    WAIT_PROTO,
    DONE,
    ERR
  } seq_state_t;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic        has_vlan;
    logic [11:0] vlan_id;
    logic [15:0] ethertype;
    logic [3:0]  proto_class;
  } eth_metadata_t;

endpackage

// File: rtl/parse_stage_sequencer_if.sv
// Bundle of frame/stage strobes, metadata in/out handshake and error reporting for the sequencer.
interface parse_stage_sequencer_if
  import eth_parser_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic          frame_start;
  logic          frame_end;
  logic          fields_valid;
  logic          vlan_valid;
  logic          proto_valid;
  eth_metadata_t md_in;
  eth_metadata_t md_out;
  logic          md_out_valid;
  logic          md_out_ready;
  logic          err_order;
  logic          err_incomplete;
  logic          overflow;
  logic [CNT_W-1:0] order_err_cnt;
  logic [CNT_W-1:0] incomplete_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output frame_start, frame_end, fields_valid, vlan_valid, proto_valid, md_in, md_out_ready,
    input  md_out, md_out_valid, err_order, err_incomplete, overflow,
           order_err_cnt, incomplete_cnt, drop_cnt
  );

  modport slave (
    input  frame_start, frame_end, fields_valid, vlan_valid, proto_valid, md_in, md_out_ready,
    output md_out, md_out_valid, err_order, err_incomplete, overflow,
           order_err_cnt, incomplete_cnt, drop_cnt
  );
endinterface

// File: rtl/parse_stage_sequencer_md_fifo.sv
// Sync FIFO of metadata records; head is registered storage, 1-cycle push-to-visible latency.
// A push while full is accepted only if a pop frees a slot in the same cycle, otherwise ignored.
module md_fifo
  import eth_parser_pkg::*;
#(
  parameter int DEPTH = PSS_DEFAULT_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  eth_metadata_t data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output eth_metadata_t head_o
);
  localparam int AW = $clog2(DEPTH);

  eth_metadata_t mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          do_pop, do_push;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
endmodule

// File: rtl/parse_stage_sequencer.sv
// Per-frame stage-order checker (fields->vlan->proto) committing metadata to a ready/valid queue.
// Commit visible 1 cycle after frame_end; full queue drops the record. PSS_WATCHDOG_EN adds a frame timeout.
module parse_stage_sequencer
  import eth_parser_pkg::*;
#(
  parameter int FIFO_DEPTH = PSS_DEFAULT_DEPTH,
  parameter int CNT_W      = 16
`ifdef PSS_WATCHDOG_EN
  , parameter int TIMEOUT_CYCLES = 2048
`endif
) (
  input logic                  clk,
  input logic                  rst_n,
  parse_stage_sequencer_if.slave bus_if
);
  seq_state_t       state_q, state_d, nxt_stage;
  logic [2:0]       stb;
  logic             any_stb, stb_ok, close, timeout, checks_stb, in_wait;
  logic             commit, pop, fifo_full, fifo_empty;
  logic             ord_d, inc_d, drop_d;
  logic             err_order_q, err_incomplete_q, overflow_q;
  logic [CNT_W-1:0] order_cnt_q, inc_cnt_q, drop_cnt_q;

  assign stb        = {bus_if.proto_valid, bus_if.vlan_valid, bus_if.fields_valid};
  assign any_stb    = |stb;
  // frame_start on an open frame closes it exactly like frame_end would
  assign close      = bus_if.frame_start | bus_if.frame_end;
  assign in_wait    = state_q inside {WAIT_HDR, WAIT_VLAN, WAIT_PROTO};
  assign checks_stb = in_wait || (state_q == DONE);
  assign commit     = close && (state_q == DONE);
  assign pop        = bus_if.md_out_ready & ~fifo_empty;

  always_comb begin
    stb_ok    = 1'b0;
    nxt_stage = ERR;
    case (state_q)
      WAIT_HDR:   begin stb_ok = (stb == 3'b001); nxt_stage = WAIT_VLAN;  end
      WAIT_VLAN:  begin stb_ok = (stb == 3'b010); nxt_stage = WAIT_PROTO; end
      WAIT_PROTO: begin stb_ok = (stb == 3'b100); nxt_stage = DONE;       end
      default:    ;
    endcase
  end

`ifdef PSS_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q;

  // wd_cnt_q equals the number of cycles since the frame_start edge
  assign timeout = (state_q != IDLE) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else if (bus_if.frame_start) begin
      wd_cnt_q <= WD_W'(1);
    end else if ((state_q != IDLE) && !close && !timeout) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (close)                      state_d = bus_if.frame_start ? WAIT_HDR : IDLE;
    else if (timeout)               state_d = IDLE;
    else if (checks_stb && any_stb) state_d = stb_ok ? nxt_stage : ERR;
  end

  // A strobe arriving with frame_end is ignored: the frame closes on its current stage.
  assign ord_d  = !close && !timeout && checks_stb && any_stb && !stb_ok;
  assign inc_d  = (close && in_wait) || (!close && timeout);
  assign drop_d = commit && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      err_order_q      <= 1'b0;
      err_incomplete_q <= 1'b0;
      overflow_q       <= 1'b0;
      order_cnt_q      <= '0;
      inc_cnt_q        <= '0;
      drop_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      err_order_q      <= ord_d;
      err_incomplete_q <= inc_d;
      overflow_q       <= drop_d;
      if (ord_d && !(&order_cnt_q)) order_cnt_q <= order_cnt_q + 1'b1;
      if (inc_d && !(&inc_cnt_q))   inc_cnt_q   <= inc_cnt_q + 1'b1;
      if (drop_d && !(&drop_cnt_q)) drop_cnt_q  <= drop_cnt_q + 1'b1;
    end
  end

  md_fifo #(.DEPTH(FIFO_DEPTH)) u_md_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (commit),
    .data_i  (bus_if.md_in),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (bus_if.md_out)
  );

  assign bus_if.md_out_valid   = ~fifo_empty;
  assign bus_if.err_order      = err_order_q;
  assign bus_if.err_incomplete = err_incomplete_q;
  assign bus_if.overflow       = overflow_q;
  assign bus_if.order_err_cnt  = order_cnt_q;
  assign bus_if.incomplete_cnt = inc_cnt_q;
  assign bus_if.drop_cnt       = drop_cnt_q;
endmodule

// File: tb/tb_parse_stage_sequencer.sv
// Directed spec scenarios then randomized traffic, checked against a frame-level reference model.
module tb_parse_stage_sequencer;
  import eth_parser_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int TO    = 16;
`ifdef PSS_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  parse_stage_sequencer_if #(.CNT_W(CW)) bus ();

`ifdef PSS_WATCHDOG_EN
  parse_stage_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus_if(bus.slave));
`else
  parse_stage_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus_if(bus.slave));
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: is a frame open, which stage (1..3) is expected next (4 = all seen),
  // has it gone bad, cycles since start, plus the expected record queue and counters.
  bit            m_open, m_bad;
  int            m_stage, m_age;
  eth_metadata_t m_q[$];
  int            m_ord, m_inc, m_drop;
  bit            e_ord, e_inc, e_ovf;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_bad = 0; m_stage = 1; m_age = 0;
    m_q.delete();
    m_ord = 0; m_inc = 0; m_drop = 0;
    e_ord = 0; e_inc = 0; e_ovf = 0;
  endtask

  task automatic model(input bit st, en, f, v, p, rdy, input eth_metadata_t md);
    bit pop, full, push;
    int nstb, idx;
    pop  = rdy && (m_q.size() > 0);
    full = (m_q.size() == DEPTH);
    push = 0;
    nstb = int'(f) + int'(v) + int'(p);
    idx  = f ? 1 : (v ? 2 : 3);
    e_ord = 0; e_inc = 0; e_ovf = 0;
    if (st || en) begin
      if (m_open && !m_bad) begin
        if (m_stage == 4) push = 1;
        else e_inc = 1;
      end
      m_open = st; m_stage = 1; m_bad = 0; m_age = 1;
    end else if (m_open) begin
      if (WD && m_age >= TO) begin
        e_inc = 1; m_open = 0;
      end else begin
        m_age++;
        if (!m_bad && nstb > 0) begin
          if (nstb == 1 && idx == m_stage) m_stage++;
          else begin e_ord = 1; m_bad = 1; end
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (!full || pop) m_q.push_back(md);
      else e_ovf = 1;
    end
    if (e_ord && m_ord < CMAX) m_ord++;
    if (e_inc && m_inc < CMAX) m_inc++;
    if (e_ovf && m_drop < CMAX) m_drop++;
  endtask

  task automatic check_all();
    chk("md_out_valid", 192'(bus.md_out_valid), 192'(m_q.size() > 0));
    if (m_q.size() > 0) chk("md_out", 192'(bus.md_out), 192'(m_q[0]));
    chk("err_order", 192'(bus.err_order), 192'(e_ord));
    chk("err_incomplete", 192'(bus.err_incomplete), 192'(e_inc));
    chk("overflow", 192'(bus.overflow), 192'(e_ovf));
    chk("order_err_cnt", 192'(bus.order_err_cnt), 192'(m_ord));
    chk("incomplete_cnt", 192'(bus.incomplete_cnt), 192'(m_inc));
    chk("drop_cnt", 192'(bus.drop_cnt), 192'(m_drop));
  endtask

  function automatic eth_metadata_t rand_md();
    eth_metadata_t m;
    m.dst_mac     = 48'({$urandom(), $urandom()});
    m.src_mac     = 48'({$urandom(), $urandom()});
    m.has_vlan    = 1'($urandom());
    m.vlan_id     = 12'($urandom());
    m.ethertype   = 16'($urandom());
    m.proto_class = 4'($urandom());
    return m;
  endfunction

  task automatic cyc(input bit st, en, f, v, p, rdy, input eth_metadata_t md);
    bus.frame_start  = st;
    bus.frame_end    = en;
    bus.fields_valid = f;
    bus.vlan_valid   = v;
    bus.proto_valid  = p;
    bus.md_out_ready = rdy;
    bus.md_in        = md;
    model(st, en, f, v, p, rdy, md);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rdy, rand_md());
  endtask

  task automatic good_frame(input logic [11:0] vid, input bit rdy);
    eth_metadata_t m;
    m = rand_md();
    m.vlan_id = vid;
    cyc(1, 0, 0, 0, 0, rdy, rand_md());
    cyc(0, 0, 1, 0, 0, rdy, rand_md());
    cyc(0, 0, 0, 1, 0, rdy, rand_md());
    cyc(0, 0, 0, 0, 1, rdy, rand_md());
    cyc(0, 1, 0, 0, 0, rdy, m);
  endtask

  initial begin
    eth_metadata_t md;
    bit st, en, f, v, p;
    int k, rdy_pct;

    bus.frame_start = 0; bus.frame_end = 0; bus.fields_valid = 0;
    bus.vlan_valid = 0; bus.proto_valid = 0; bus.md_out_ready = 0; bus.md_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_md_out", 192'(bus.md_out), 192'(0));
    check_all();
    rst_n = 1'b1;

    // In-order frame, strobes at +2/+4/+6, end at +9
    md = rand_md();
    md.vlan_id = 12'h064;
    cyc(1, 0, 0, 0, 0, 0, rand_md());
    idle(1, 0);
    cyc(0, 0, 1, 0, 0, 0, rand_md());
    idle(1, 0);
    cyc(0, 0, 0, 1, 0, 0, rand_md());
    idle(1, 0);
    cyc(0, 0, 0, 0, 1, 0, rand_md());
    idle(2, 0);
    chk("t1_not_early", 192'(bus.md_out_valid), 192'(0));
    cyc(0, 1, 0, 0, 0, 0, md);
    chk("t1_valid", 192'(bus.md_out_valid), 192'(1));
    chk("t1_vlan_id", 192'(bus.md_out.vlan_id), 192'(12'h064));
    idle(2, 0);
    chk("t1_hold", 192'(bus.md_out.vlan_id), 192'(12'h064));
    idle(1, 1);

    // vlan before fields
    cyc(1, 0, 0, 0, 0, 1, rand_md());
    cyc(0, 0, 0, 1, 0, 1, rand_md());
    chk("t2_err_order", 192'(bus.err_order), 192'(1));
    chk("t2_cnt", 192'(bus.order_err_cnt), 192'(1));
    cyc(0, 0, 0, 0, 1, 1, rand_md());
    cyc(0, 1, 0, 0, 0, 1, rand_md());
    chk("t2_no_push", 192'(bus.md_out_valid), 192'(0));

    // end after vlan only
    cyc(1, 0, 0, 0, 0, 1, rand_md());
    cyc(0, 0, 1, 0, 0, 1, rand_md());
    cyc(0, 0, 0, 1, 0, 1, rand_md());
    cyc(0, 1, 0, 0, 0, 1, rand_md());
    chk("t3_err_inc", 192'(bus.err_incomplete), 192'(1));
    chk("t3_cnt", 192'(bus.incomplete_cnt), 192'(1));
    idle(1, 1);
    chk("t3_no_push", 192'(bus.md_out_valid), 192'(0));

    // five frames with ready low: fifth dropped, drain 1..4 in order
    for (int i = 1; i <= 5; i++) good_frame(12'(i), 0);
    chk("t4_overflow", 192'(bus.overflow), 192'(1));
    chk("t4_drop_cnt", 192'(bus.drop_cnt), 192'(1));
    for (int i = 1; i <= 4; i++) begin
      chk("t4_drain_vid", 192'(bus.md_out.vlan_id), 192'(i));
      idle(1, 1);
    end
    chk("t4_empty", 192'(bus.md_out_valid), 192'(0));

    // start+end in DONE: commit and open next frame
    md = rand_md();
    cyc(1, 0, 0, 0, 0, 0, rand_md());
    cyc(0, 0, 1, 0, 0, 0, rand_md());
    cyc(0, 0, 0, 1, 0, 0, rand_md());
    cyc(0, 0, 0, 0, 1, 0, rand_md());
    cyc(1, 1, 0, 0, 0, 0, md);
    chk("t5_commit", 192'(bus.md_out), 192'(md));
    cyc(0, 0, 1, 0, 0, 0, rand_md());
    chk("t5_no_err", 192'(bus.err_order), 192'(0));
    cyc(0, 0, 0, 1, 0, 1, rand_md());
    // proto together with end: still incomplete
    cyc(0, 1, 0, 0, 1, 1, rand_md());
    chk("t6_inc", 192'(bus.err_incomplete), 192'(1));
    idle(1, 1);

`ifdef PSS_WATCHDOG_EN
    cyc(1, 0, 0, 0, 0, 1, rand_md());
    for (int i = 1; i < TO; i++) begin
      cyc(0, 0, 0, 0, 0, 1, rand_md());
      chk("wd_early", 192'(bus.err_incomplete), 192'(0));
    end
    cyc(0, 0, 0, 0, 0, 1, rand_md());
    chk("wd_fire", 192'(bus.err_incomplete), 192'(1));
    cyc(0, 0, 0, 0, 1, 1, rand_md());
    chk("wd_late_ignored", 192'(bus.err_order), 192'(0));
`endif

    // async reset mid-frame with records queued
    good_frame(12'h0AA, 0);
    cyc(1, 0, 0, 0, 0, 0, rand_md());
    cyc(0, 0, 1, 0, 0, 0, rand_md());
    #2 rst_n = 1'b0;
    #1;
    bus.frame_start = 0; bus.frame_end = 0; bus.fields_valid = 0;
    bus.vlan_valid = 0; bus.proto_valid = 0;
    model_reset();
    chk("rst_md_out", 192'(bus.md_out), 192'(0));
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 1, 0, 0, 0, rand_md());
    chk("rst_idle_ignores", 192'(bus.err_order), 192'(0));

    // randomized traffic, biased towards the expected stage so commits occur
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rdy_pct = ($urandom_range(0, 1) != 0) ? 85 : 10;
      st = ($urandom_range(0, 99) < 6);
      en = ($urandom_range(0, 99) < 7);
      f = 0; v = 0; p = 0;
      if ($urandom_range(0, 99) < 35) begin
        k = (m_open && $urandom_range(0, 3) != 0) ? m_stage : int'($urandom_range(1, 3));
        if ($urandom_range(0, 99) < 5) begin
          f = 1'($urandom); v = 1'($urandom); p = 1'($urandom);
        end
        if (k == 1) f = 1;
        if (k == 2) v = 1;
        if (k == 3) p = 1;
      end
      cyc(st, en, f, v, p, ($urandom_range(0, 99) < rdy_pct), rand_md());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
